// File: rtl/mod_counter_prog.sv
// Runtime-programmable modulo counter with up/down, load, clear and one-shot stop.
// A qualified terminal-count strobe lets several stages cascade into wider dividers.
module mod_counter_prog #(
    parameter int N     = 8,
    parameter int M_RST = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         dir,
    input  logic         clr,
    input  logic         ld,
    input  logic [N-1:0] d,
    input  logic         top_we,
    input  logic [N-1:0] top_in,
    input  logic         one_shot,
    output logic [N-1:0] q,
    output logic         max_tick,
    output logic         min_tick,
    output logic         tc,
    output logic         done
);

    logic [N-1:0] top;
    logic         term;
    logic         run;

    // Counting up uses >= so a q left above a shrunken top still wraps on the next count.
    assign term     = dir ? (q >= top) : (q == '0);
    assign run      = en & ~done;
    assign tc       = term & run & ~clr & ~ld;
    assign max_tick = (q == top);
    assign min_tick = (q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= '0;
            done <= 1'b0;
        end else if (clr) begin
            q    <= '0;
            done <= 1'b0;
        end else if (ld) begin
            q    <= d;
            done <= 1'b0;
        end else if (run) begin
            if (!term) begin
                q <= dir ? q + N'(1) : q - N'(1);
            end else if (!one_shot) begin
                q <= dir ? '0 : top;
            end else begin
                done <= 1'b1;
            end
        end
    end

    // The count path above reads the old top in the cycle a write lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top <= N'(M_RST - 1);
        end else if (top_we) begin
            top <= top_in;
        end
    end

endmodule

// File: tb/tb_mod_counter_prog.sv
// Directed-vector bench for mod_counter_prog; expected outputs are queued per cycle
// by the stimulus and consumed by an independent monitor.
module tb_mod_counter_prog;

    logic       clk;
    logic       reset;
    logic       en;
    logic       dir;
    logic       clr;
    logic       ld;
    logic [7:0] d;
    logic       top_we;
    logic [7:0] top_in;
    logic       one_shot;
    logic [7:0] q;
    logic       max_tick;
    logic       min_tick;
    logic       tc;
    logic       done;

    mod_counter_prog #(.N(8), .M_RST(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .dir      (dir),
        .clr      (clr),
        .ld       (ld),
        .d        (d),
        .top_we   (top_we),
        .top_in   (top_in),
        .one_shot (one_shot),
        .q        (q),
        .max_tick (max_tick),
        .min_tick (min_tick),
        .tc       (tc),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] q;
        logic       mx;
        logic       mn;
        logic       tc;
        logic       dn;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         step  = 0;
    logic [7:0] cur_top = 8'd9;
    logic       pend_we = 1'b0;
    logic [7:0] pend_val = 8'd0;

    task automatic push_exp(input logic [7:0] eq, input logic etc, input logic edn);
        exp_t e;
        e.id = step;
        e.q  = eq;
        e.mx = (eq == cur_top);
        e.mn = (eq == 8'd0);
        e.tc = etc;
        e.dn = edn;
        exp_q.push_back(e);
        step++;
    endtask

    task automatic wtop(input logic [7:0] v);
        pend_we  = 1'b1;
        pend_val = v;
    endtask

    // One cycle: drive inputs, queue what the outputs must show before the next edge.
    task automatic cyc(input logic e, input logic dr, input logic c, input logic l,
                       input logic [7:0] dv, input logic os,
                       input logic [7:0] eq, input logic etc, input logic edn);
        @(negedge clk);
        en       = e;
        dir      = dr;
        clr      = c;
        ld       = l;
        d        = dv;
        one_shot = os;
        top_we   = pend_we;
        top_in   = pend_val;
        push_exp(eq, etc, edn);
        if (pend_we) cur_top = pend_val;
        pend_we = 1'b0;
    endtask

    task automatic chk(input int id, input string nm, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL step%0d %s: got %0d want %0d", id, nm, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.id, "q", q, e.q);
                chk(e.id, "max_tick", {7'd0, max_tick}, {7'd0, e.mx});
                chk(e.id, "min_tick", {7'd0, min_tick}, {7'd0, e.mn});
                chk(e.id, "tc", {7'd0, tc}, {7'd0, e.tc});
                chk(e.id, "done", {7'd0, done}, {7'd0, e.dn});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b1; en = 1'b0; dir = 1'b1; clr = 1'b0; ld = 1'b0;
        d = 8'd0; top_we = 1'b0; top_in = 8'd0; one_shot = 1'b0;

        @(negedge clk);
        push_exp(8'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // free-run up, modulus 10
        for (int i = 0; i < 21; i++)
            cyc(1, 1, 0, 0, 8'd0, 0, 8'(i % 10), (i % 10) == 9, 0);

        // top shrinks to 3 while q=7: old top used once, then 8 wraps
        for (int i = 1; i < 7; i++)
            cyc(1, 1, 0, 0, 8'd0, 0, 8'(i), 0, 0);
        wtop(8'd3);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd7, 0, 0);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd8, 1, 0);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd0, 0, 0);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd1, 0, 0);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd2, 0, 0);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd3, 1, 0);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd0, 0, 0);

        // count down with top=5 and one idle cycle
        wtop(8'd5);
        cyc(1, 1, 1, 0, 8'd0, 0, 8'd1, 0, 0);
        cyc(1, 0, 0, 0, 8'd0, 0, 8'd0, 1, 0);
        cyc(1, 0, 0, 0, 8'd0, 0, 8'd5, 0, 0);
        cyc(1, 0, 0, 0, 8'd0, 0, 8'd4, 0, 0);
        cyc(0, 0, 0, 0, 8'd0, 0, 8'd3, 0, 0);
        cyc(1, 0, 0, 0, 8'd0, 0, 8'd3, 0, 0);
        cyc(1, 0, 0, 0, 8'd0, 0, 8'd2, 0, 0);
        cyc(1, 0, 0, 0, 8'd0, 0, 8'd1, 0, 0);
        cyc(1, 0, 0, 0, 8'd0, 0, 8'd0, 1, 0);
        cyc(1, 0, 0, 0, 8'd0, 0, 8'd5, 0, 0);

        // one-shot up to top=4, hold, reload, deassert one_shot
        wtop(8'd4);
        cyc(1, 1, 1, 0, 8'd0, 1, 8'd4, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc(1, 1, 0, 0, 8'd0, 1, 8'(i), 0, 0);
        cyc(1, 1, 0, 0, 8'd0, 1, 8'd4, 1, 0);
        for (int i = 0; i < 10; i++)
            cyc(1, 1, 0, 0, 8'd0, 1, 8'd4, 0, 1);
        cyc(1, 1, 0, 1, 8'd2, 1, 8'd4, 0, 1);
        cyc(1, 1, 0, 0, 8'd0, 1, 8'd2, 0, 0);
        cyc(1, 1, 0, 0, 8'd0, 1, 8'd3, 0, 0);
        cyc(1, 1, 0, 0, 8'd0, 1, 8'd4, 1, 0);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd4, 0, 1);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd4, 0, 1);

        // clr beats ld; ld suppresses count; loaded q above top wraps
        cyc(1, 1, 1, 1, 8'd7, 0, 8'd4, 0, 1);
        cyc(1, 1, 0, 1, 8'd7, 0, 8'd0, 0, 0);
        cyc(0, 1, 0, 0, 8'd0, 0, 8'd7, 0, 0);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd7, 1, 0);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd0, 0, 0);

        // reach q=6, top=3, done=1, then async reset between edges
        wtop(8'd3);
        cyc(0, 1, 0, 1, 8'd6, 1, 8'd1, 0, 0);
        cyc(1, 1, 0, 0, 8'd0, 1, 8'd6, 1, 0);
        cyc(1, 1, 0, 0, 8'd0, 1, 8'd6, 0, 1);
        @(negedge clk);
        en = 1'b0;
        one_shot = 1'b0;
        #1;
        reset = 1'b1;
        cur_top = 8'd9;
        push_exp(8'd0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 11; i++)
            cyc(1, 1, 0, 0, 8'd0, 0, 8'(i % 10), (i % 10) == 9, 0);

        @(negedge clk);
        en = 1'b0;
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
